memgame_seq_engine: RTL and testbench

Parametrised successor to the single-player memory-game controller. It stores a random digit sequence in an internal buffer of up to DEPTH entries and plays it back with internally generated display timing, so no external one-second timer is needed. It then checks player entries against the stored sequence.
- Mode 0: the whole sequence is regenerated each level.
- Mode 1: classic append-one-per-level play.
- Optional input timeout.
- Sits between the button shapers / RNG and the seven-segment decoders.

---
 rtl/memgame_pkg.sv | 26 ++
 rtl/memgame_seq_engine_if.sv | 40 ++++
 rtl/memgame_tick_timer.sv | 40 ++++
 rtl/memgame_seq_engine.sv | 182 ++++++++++++++++++
 tb/tb_memgame_seq_engine.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memgame_pkg.sv
// memgame_pkg
// Shared types and helpers for the memory-game sequence engine:
//   - state_e     : controller state encoding (3 bits)
//   - MODE_REGEN  : regenerate the whole sequence on every level
//   - MODE_APPEND : add one new digit per level
//   - cnt_width() : width needed to hold a count of 0..depth
package memgame_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_SHOW  = 3'd2,
    S_GAP   = 3'd3,
    S_INPUT = 3'd4,
    S_DONE  = 3'd5,
    S_FAIL  = 3'd6
  } state_e;

  localparam logic MODE_REGEN  = 1'b0;
  localparam logic MODE_APPEND = 1'b1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/memgame_seq_engine_if.sv
// memgame_seq_engine_if
// Bundles the game-side signals of the sequence engine.
//   master : the environment (buttons, RNG, switches, display decoders)
//   slave  : the engine itself
// Inputs to engine : start_p, mode, rand_num, enter_p, guess
// Outputs of engine: disp_digit, disp_valid, echo_digit, points, level,
//                    busy, await_in, win, lose
interface memgame_seq_engine_if #(
  parameter int DIGIT_W = 4,
  parameter int CNT_W   = 5
);

  logic               start_p;
  logic               mode;
  logic [DIGIT_W-1:0] rand_num;
  logic               enter_p;
  logic [DIGIT_W-1:0] guess;
  logic [DIGIT_W-1:0] disp_digit;
  logic               disp_valid;
  logic [DIGIT_W-1:0] echo_digit;
  logic [CNT_W-1:0]   points;
  logic [CNT_W-1:0]   level;
  logic               busy;
  logic               await_in;
  logic               win;
  logic               lose;

  modport master (
    output start_p, mode, rand_num, enter_p, guess,
    input  disp_digit, disp_valid, echo_digit, points, level,
           busy, await_in, win, lose
  );

  modport slave (
    input  start_p, mode, rand_num, enter_p, guess,
    output disp_digit, disp_valid, echo_digit, points, level,
           busy, await_in, win, lose
  );

endinterface

// File: rtl/memgame_tick_timer.sv
// memgame_tick_timer
// Loadable down-counter shared by digit display, inter-digit gap and the
// player-entry timeout. It stops at zero; a load of zero leaves it idle.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : value to load
//   expired    : high while the count equals 1, i.e. the last cycle of the
//                interval that was loaded
module memgame_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == W'(1));

endmodule

// File: rtl/memgame_seq_engine.sv
// memgame_seq_engine
// Memory-game controller: stores a random digit sequence, plays it back with
// internal show/gap timing, then checks the player's entries against it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : memgame_seq_engine_if.slave
//                start_p/enter_p pulses, mode, rand_num, guess in;
//                display, echo, score, level and status flags out
module memgame_seq_engine
  import memgame_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int DIGIT_W       = 4,
  parameter int SHOW_TICKS    = 50000000,
  parameter int GAP_TICKS     = 12500000,
  parameter int TIMEOUT_TICKS = 0,
  parameter int CNT_W         = cnt_width(DEPTH)
) (
  input logic                clk,
  input logic                rst_n,
  memgame_seq_engine_if.slave bus
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMAX_SG = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TMAX    = (TMAX_SG > TIMEOUT_TICKS) ? TMAX_SG : TIMEOUT_TICKS;
  localparam int TIMER_W = $clog2(TMAX + 1);

  localparam logic [TIMER_W-1:0] SHOW_LD = TIMER_W'(SHOW_TICKS);
  localparam logic [TIMER_W-1:0] GAP_LD  = TIMER_W'(GAP_TICKS);
  localparam logic [TIMER_W-1:0] TO_LD   = TIMER_W'(TIMEOUT_TICKS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   points_q, points_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DIGIT_W-1:0] echo_q, echo_d;
  logic               mode_q, mode_d;
  logic [DIGIT_W-1:0] mem_q [DEPTH];
  logic [DIGIT_W-1:0] mem_d [DEPTH];

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_expired;
  logic [CNT_W-1:0]   last_idx;
  logic [DIGIT_W-1:0] cur_digit;

  assign last_idx  = level_q - CNT_W'(1);
  assign cur_digit = mem_q[idx_q[IDX_W-1:0]];

  memgame_tick_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    points_d = points_q;
    idx_d    = idx_q;
    echo_d   = echo_q;
    mode_d   = mode_q;
    mem_d    = mem_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    // start_p restarts from any state and beats a simultaneous enter_p.
    if (bus.start_p) begin
      state_d  = S_GEN;
      level_d  = CNT_W'(1);
      points_d = '0;
      idx_d    = '0;
      mode_d   = bus.mode;
    end else begin
      case (state_q)
        S_GEN: begin
          // Append mode only fills the newest slot; regen mode walks idx
          // across the whole level, one digit per cycle.
          if (mode_q == MODE_APPEND) begin
            mem_d[last_idx[IDX_W-1:0]] = bus.rand_num;
          end else begin
            mem_d[idx_q[IDX_W-1:0]] = bus.rand_num;
          end
          if (mode_q == MODE_APPEND || idx_q == last_idx) begin
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = SHOW_LD;
            state_d  = S_SHOW;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
        S_SHOW: begin
          if (tmr_expired) begin
            tmr_load = 1'b1;
            if (idx_q == last_idx) begin
              idx_d   = '0;
              tmr_val = TO_LD;
              state_d = S_INPUT;
            end else begin
              tmr_val = GAP_LD;
              state_d = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (tmr_expired) begin
            idx_d    = idx_q + CNT_W'(1);
            tmr_load = 1'b1;
            tmr_val  = SHOW_LD;
            state_d  = S_SHOW;
          end
        end
        S_INPUT: begin
          if (bus.enter_p) begin
            echo_d = bus.guess;
            if (bus.guess != cur_digit) begin
              state_d = S_FAIL;
            end else if (idx_q != last_idx) begin
              idx_d    = idx_q + CNT_W'(1);
              tmr_load = 1'b1;
              tmr_val  = TO_LD;
            end else begin
              points_d = (points_q == CNT_W'(DEPTH)) ? points_q : points_q + CNT_W'(1);
              if (level_q == CNT_W'(DEPTH)) begin
                state_d = S_DONE;
              end else begin
                level_d = level_q + CNT_W'(1);
                idx_d   = '0;
                state_d = S_GEN;
              end
            end
          end else if (TIMEOUT_TICKS != 0 && tmr_expired) begin
            state_d = S_FAIL;
          end
        end
        S_IDLE, S_DONE, S_FAIL: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      points_q <= '0;
      idx_q    <= '0;
      echo_q   <= '0;
      mode_q   <= MODE_REGEN;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      points_q <= points_d;
      idx_q    <= idx_d;
      echo_q   <= echo_d;
      mode_q   <= mode_d;
    end
  end

  // Sequence buffer carries no reset; its contents are rewritten before use.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.disp_valid = (state_q == S_SHOW);
  assign bus.disp_digit = (state_q == S_SHOW) ? cur_digit : '0;
  assign bus.echo_digit = echo_q;
  assign bus.points     = points_q;
  assign bus.level      = level_q;
  assign bus.busy       = (state_q == S_GEN) || (state_q == S_SHOW) || (state_q == S_GAP);
  assign bus.await_in   = (state_q == S_INPUT);
  assign bus.win        = (state_q == S_DONE);
  assign bus.lose       = (state_q == S_FAIL);

endmodule

// File: tb/tb_memgame_seq_engine.sv
// tb_memgame_seq_engine
// Self-checking bench for memgame_seq_engine (DEPTH=4, DIGIT_W=4,
// SHOW_TICKS=3, GAP_TICKS=1). A second instance with TIMEOUT_TICKS=10
// covers the entry timeout. The reference model keeps the game as a digit
// queue plus level/points/echo and derives display timing arithmetically.
module tb_memgame_seq_engine;

  localparam int DEPTH = 4;
  localparam int SHOW  = 3;
  localparam int GAP   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memgame_seq_engine_if #(.DIGIT_W(4), .CNT_W(3)) bus ();
  memgame_seq_engine_if #(.DIGIT_W(4), .CNT_W(3)) bus_to ();

  memgame_seq_engine #(
    .DEPTH(DEPTH), .DIGIT_W(4), .SHOW_TICKS(SHOW), .GAP_TICKS(GAP),
    .TIMEOUT_TICKS(0), .CNT_W(3)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  memgame_seq_engine #(
    .DEPTH(DEPTH), .DIGIT_W(4), .SHOW_TICKS(SHOW), .GAP_TICKS(GAP),
    .TIMEOUT_TICKS(10), .CNT_W(3)
  ) dut_to (.clk(clk), .rst_n(rst_n), .bus(bus_to));

  int n_tests = 0;
  int n_fails = 0;

  int seq[$];
  int forced_rand[$];
  int m_level, m_points, m_echo;
  bit m_mode, m_lost, m_won;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_rand();
    if (forced_rand.size() > 0) return forced_rand.pop_front();
    return int'($urandom_range(0, 15));
  endfunction

  // Drive one cycle of inputs; pulses are dropped again after the edge.
  task automatic applyStimulus(input bit s, input bit e, input int g, input int r);
    bus.start_p  = s;
    bus.enter_p  = e;
    bus.guess    = 4'(g);
    bus.rand_num = 4'(r);
    if (!s) bus.mode = 1'($urandom_range(0, 1));
    tick();
    bus.start_p = 1'b0;
    bus.enter_p = 1'b0;
  endtask

  // Idle cycle with an occasional stray enter that must be ignored.
  task automatic noise_cycle();
    applyStimulus(0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_disp_digit"}, bus.disp_digit, 0);
    checkOutput({tag, "_disp_valid"}, bus.disp_valid, 0);
    checkOutput({tag, "_echo"},       bus.echo_digit, 0);
    checkOutput({tag, "_points"},     bus.points, 0);
    checkOutput({tag, "_level"},      bus.level, 0);
    checkOutput({tag, "_busy"},       bus.busy, 0);
    checkOutput({tag, "_await"},      bus.await_in, 0);
    checkOutput({tag, "_win"},        bus.win, 0);
    checkOutput({tag, "_lose"},       bus.lose, 0);
  endtask

  task automatic start_game(input bit m, input bit with_enter, input int g);
    bus.mode = m;
    applyStimulus(1, with_enter, g, int'($urandom_range(0, 15)));
    m_mode = m; m_level = 1; m_points = 0; m_lost = 0; m_won = 0;
    seq.delete();
    checkOutput("start_busy",   bus.busy, 1);
    checkOutput("start_level",  bus.level, 1);
    checkOutput("start_points", bus.points, 0);
    checkOutput("start_echo",   bus.echo_digit, m_echo);
  endtask

  // Append mode adds one digit; regen mode draws a fresh digit per position.
  task automatic gen_phase();
    int n;
    n = m_mode ? 1 : m_level;
    if (!m_mode) seq.delete();
    for (int i = 0; i < n; i++) begin
      int r;
      r = next_rand();
      checkOutput("gen_busy",  bus.busy, 1);
      checkOutput("gen_valid", bus.disp_valid, 0);
      applyStimulus(0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), r);
      seq.push_back(r);
    end
  endtask

  task automatic show_phase();
    for (int i = 0; i < m_level; i++) begin
      for (int c = 0; c < SHOW; c++) begin
        checkOutput("show_valid", bus.disp_valid, 1);
        checkOutput("show_digit", bus.disp_digit, seq[i]);
        noise_cycle();
      end
      if (i < m_level - 1) begin
        for (int c = 0; c < GAP; c++) begin
          checkOutput("gap_valid", bus.disp_valid, 0);
          checkOutput("gap_digit", bus.disp_digit, 0);
          checkOutput("gap_busy",  bus.busy, 1);
          noise_cycle();
        end
      end
    end
    checkOutput("await_in",   bus.await_in, 1);
    checkOutput("await_busy", bus.busy, 0);
    checkOutput("await_echo", bus.echo_digit, m_echo);
  endtask

  task automatic enter_guess(input int idx, input int g);
    applyStimulus(0, 1, g, int'($urandom_range(0, 15)));
    m_echo = g;
    checkOutput("echo", bus.echo_digit, g);
    if (g != seq[idx]) begin
      m_lost = 1;
      checkOutput("lose",       bus.lose, 1);
      checkOutput("lose_await", bus.await_in, 0);
    end else if (idx < m_level - 1) begin
      checkOutput("await_next", bus.await_in, 1);
    end else begin
      m_points++;
      if (m_level == DEPTH) begin
        m_won = 1;
        checkOutput("win", bus.win, 1);
      end else begin
        m_level++;
        checkOutput("next_busy", bus.busy, 1);
      end
    end
    checkOutput("level",  bus.level, m_level);
    checkOutput("points", bus.points, m_points);
  endtask

  // wrong_val < 0 picks a random digit different from the stored one.
  task automatic play_level(input int wrong_at, input int wrong_val);
    int lv, g;
    show_phase();
    lv = m_level;
    for (int i = 0; i < lv && !m_lost; i++) begin
      if (i != wrong_at) g = seq[i];
      else if (wrong_val < 0) g = (seq[i] + int'($urandom_range(1, 15))) % 16;
      else g = wrong_val;
      enter_guess(i, g);
    end
  endtask

  task automatic continue_game(input int wrong_level, input int wrong_at, input int wrong_val);
    gen_phase();
    while (!m_lost && !m_won) begin
      if (m_level == wrong_level) play_level(wrong_at, wrong_val);
      else play_level(-1, 0);
      if (!m_lost && !m_won) gen_phase();
    end
  endtask

  // Terminal states hold score and ignore enter_p.
  task automatic post_checks();
    applyStimulus(0, 1, (m_echo + 1) % 16, 0);
    checkOutput("post_echo",   bus.echo_digit, m_echo);
    checkOutput("post_level",  bus.level, m_level);
    checkOutput("post_points", bus.points, m_points);
    checkOutput("post_win",    bus.win, m_won ? 1 : 0);
    checkOutput("post_lose",   bus.lose, m_lost ? 1 : 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wl, wa, cnt;
    bit seen;
    bus.start_p = 0; bus.enter_p = 0; bus.mode = 0; bus.rand_num = 0; bus.guess = 0;
    bus_to.start_p = 0; bus_to.enter_p = 0; bus_to.mode = 0;
    bus_to.rand_num = 0; bus_to.guess = 0;
    m_echo = 0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // enter_p in IDLE must not touch echo_digit
    applyStimulus(0, 1, 7, 0);
    checkOutput("idle_echo", bus.echo_digit, 0);
    checkOutput("idle_busy", bus.busy, 0);

    // Append-mode win with digits 5, 9, 2, 7
    forced_rand = '{5, 9, 2, 7};
    start_game(1, 0, 0);
    continue_game(0, 0, 0);
    post_checks();

    // Regenerate mode with a counting RNG: every level shows fresh digits
    forced_rand = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    start_game(0, 0, 0);
    continue_game(0, 0, 0);
    post_checks();

    // Wrong guess at level 2 (sequence 3, 8; player enters 3 then 6),
    // after idling in INPUT with the timeout disabled
    forced_rand = '{3, 8};
    start_game(1, 0, 0);
    gen_phase();
    show_phase();
    repeat (15) applyStimulus(0, 0, 0, 0);
    checkOutput("no_timeout_await", bus.await_in, 1);
    enter_guess(0, 3);
    continue_game(2, 1, 6);
    checkOutput("wrong_echo", bus.echo_digit, 6);
    post_checks();

    // start_p and enter_p together in INPUT: restart wins, guess ignored
    start_game(1, 0, 0);
    gen_phase();
    show_phase();
    start_game(0, 1, (m_echo + 5) % 16);
    continue_game(0, 0, 0);
    post_checks();

    // Randomised games, some with a wrong entry at a random position
    repeat (8) begin
      wl = int'($urandom_range(0, 4));
      wa = (wl > 0) ? int'($urandom_range(0, wl - 1)) : 0;
      start_game(1'($urandom_range(0, 1)), 0, 0);
      continue_game(wl, wa, -1);
      post_checks();
    end

    // Asynchronous reset while a digit is displayed
    start_game(1, 0, 0);
    gen_phase();
    checkOutput("pre_reset_valid", bus.disp_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    #2 rst_n = 1'b1;
    m_echo = 0;
    tick();
    checkOutput("post_reset_busy", bus.busy, 0);
    start_game(1, 0, 0);
    continue_game(0, 0, 0);
    post_checks();

    // Entry timeout on the TIMEOUT_TICKS=10 instance
    bus_to.mode = 1'b1;
    bus_to.rand_num = 4'd4;
    bus_to.start_p = 1'b1;
    tick();
    bus_to.start_p = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = bus_to.await_in;
    end
    checkOutput("to_await_seen", seen, 1);
    cnt = 0;
    while (!bus_to.lose && cnt < 30) begin
      tick();
      cnt++;
    end
    checkOutput("timeout_cycles", cnt, 10);
    checkOutput("timeout_lose", bus_to.lose, 1);
    checkOutput("timeout_level", bus_to.level, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
